// File: rtl/jpeg_stream_sequencer.sv
// jpeg_stream_sequencer: streams a ROM-held JPEG byte stream into the header
// parser, checks SOI, stops on EOI or end of stream and tallies parser events.
module jpeg_stream_sequencer #(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] stream_len,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic [7:0]        byte_out,
    output logic              byte_valid,
    input  logic              parser_ready,
    input  logic              qtable_loaded,
    input  logic              dhttable_loaded,
    input  logic              start_scan,
    input  logic              scan_byte_valid,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code,
    output logic              eoi_seen,
    output logic [2:0]        qt_count,
    output logic [2:0]        dht_count,
    output logic [ADDR_W-1:0] scan_cnt
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    localparam logic [1:0] E_SOI    = 2'b01;
    localparam logic [1:0] E_TMO    = 2'b10;
    localparam logic [1:0] E_NOSCAN = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_SEND,
        S_DONE,
        S_ERR
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] addr_inc;
    logic [ADDR_W-1:0] len;
    logic [7:0]        byte_r;
    logic [7:0]        prev_byte;
    logic [WAIT_W-1:0] wait_cnt;
    logic              scan_seen;

    logic              start_ok;
    logic              xfer;
    logic              bad_soi;
    logic              is_eoi;
    logic              last_byte;
    logic              set_err;
    logic              set_done;
    logic              set_eoi;
    logic [1:0]        err_nxt;

    assign busy       = (state == S_FETCH) || (state == S_LOAD) ||
                        (state == S_SEND);
    assign rom_en     = (state == S_FETCH);
    assign rom_addr   = addr;
    assign byte_out   = byte_r;
    assign byte_valid = (state == S_SEND);

    assign start_ok  = start && !busy;
    assign xfer      = (state == S_SEND) && parser_ready && !abort;
    assign addr_inc  = addr + 1'b1;

    // addr doubles as the transfer index, so the SOI check keys off it
    assign bad_soi   = ((addr == '0) && (byte_r != 8'hFF)) ||
                       ((addr == ADDR_W'(1)) && (byte_r != 8'hD8));
    assign is_eoi    = (prev_byte == 8'hFF) && (byte_r == 8'hD9);
    assign last_byte = (addr_inc == len);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        set_err   = 1'b0;
        set_done  = 1'b0;
        set_eoi   = 1'b0;
        err_nxt   = 2'b00;
        if (busy && abort) begin
            state_nxt = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        if (stream_len < ADDR_W'(2)) begin
                            state_nxt = S_ERR;
                            set_err   = 1'b1;
                            err_nxt   = E_SOI;
                        end else begin
                            state_nxt = S_FETCH;
                        end
                    end
                end
                S_FETCH: state_nxt = S_LOAD;
                S_LOAD:  state_nxt = S_SEND;
                S_SEND: begin
                    if (parser_ready) begin
                        if (bad_soi) begin
                            state_nxt = S_ERR;
                            set_err   = 1'b1;
                            err_nxt   = E_SOI;
                        end else if (is_eoi || last_byte) begin
                            set_eoi = is_eoi;
                            // a start_scan coinciding with the last byte still counts
                            if (scan_seen || start_scan) begin
                                state_nxt = S_DONE;
                                set_done  = 1'b1;
                            end else begin
                                state_nxt = S_ERR;
                                set_err   = 1'b1;
                                err_nxt   = E_NOSCAN;
                            end
                        end else begin
                            state_nxt = S_FETCH;
                        end
                    end else if (wait_cnt == WAIT_LAST) begin
                        state_nxt = S_ERR;
                        set_err   = 1'b1;
                        err_nxt   = E_TMO;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr      <= '0;
            len       <= '0;
            byte_r    <= '0;
            prev_byte <= '0;
            wait_cnt  <= '0;
            scan_seen <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            err_code  <= 2'b00;
            eoi_seen  <= 1'b0;
            qt_count  <= '0;
            dht_count <= '0;
            scan_cnt  <= '0;
        end else begin
            done <= set_done;
            if (start_ok) begin
                addr      <= '0;
                len       <= stream_len;
                prev_byte <= '0;
                scan_seen <= 1'b0;
                error     <= 1'b0;
                err_code  <= 2'b00;
                eoi_seen  <= 1'b0;
                qt_count  <= '0;
                dht_count <= '0;
                scan_cnt  <= '0;
            end else begin
                if (busy && !abort) begin
                    if (qtable_loaded && (qt_count != 3'd7)) begin
                        qt_count <= qt_count + 3'd1;
                    end
                    if (dhttable_loaded && (dht_count != 3'd7)) begin
                        dht_count <= dht_count + 3'd1;
                    end
                    if (scan_byte_valid && (scan_cnt != '1)) begin
                        scan_cnt <= scan_cnt + 1'b1;
                    end
                    if (start_scan) begin
                        scan_seen <= 1'b1;
                    end
                end
                if (xfer) begin
                    addr      <= addr_inc;
                    prev_byte <= byte_r;
                end
                if (set_eoi) begin
                    eoi_seen <= 1'b1;
                end
            end
            if (set_err) begin
                error    <= 1'b1;
                err_code <= err_nxt;
            end
            if (state == S_LOAD) begin
                byte_r   <= rom_data;
                wait_cnt <= '0;
            end else if ((state == S_SEND) && !parser_ready) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
        end
    end

endmodule
